// File: rtl/video_stream_pkg.sv
// Shared types and helpers for the pixel-to-word video stream framer.
// A 24-bit {R,G,B} pixel stream is packed four pixels into three 32-bit
// words, least-significant byte first, so the byte order on the bus
// matches a plain byte copy of the pixel stream.
package video_stream_pkg;

    localparam int PIX_W  = 24;
    localparam int WORD_W = 32;

    localparam logic [3:0] KEEP_ALL = 4'hF;

    // Position of a pixel inside its 4-pixel packing group.
    // PH_LOAD pixels only fill the leftover register. Each later phase
    // completes one output word.
    typedef enum logic [1:0] {
        PH_LOAD   = 2'd0,
        PH_FIRST  = 2'd1,
        PH_SECOND = 2'd2,
        PH_THIRD  = 2'd3
    } phase_e;

    // Combines the bytes left over from earlier pixels with the current
    // pixel to form the word completed in this phase. The low bytes of
    // the word always come from the older data.
    function automatic logic [WORD_W-1:0] pack_word(
        input phase_e           phase,
        input logic [PIX_W-1:0] lo,
        input logic [PIX_W-1:0] p
    );
        logic [WORD_W-1:0] w;
        case (phase)
            PH_FIRST:  w = {p[7:0],  lo[23:0]};
            PH_SECOND: w = {p[15:0], lo[15:0]};
            PH_THIRD:  w = {p[23:0], lo[7:0]};
            default:   w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/axis_out_slice.sv
// Single register slice that drives the AXI4-Stream output.
// A new word may be loaded whenever the slice is empty or its current word
// is being taken this cycle. A word that is stalled is never overwritten,
// so tdata/tuser/tlast stay stable while tvalid && !tready.
module axis_out_slice
    import video_stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_user,
    input  logic              load_last,
    output logic              can_load,
    output logic [WORD_W-1:0] tdata,
    output logic [3:0]        tkeep,
    output logic              tvalid,
    input  logic              tready,
    output logic              tuser,
    output logic              tlast
);

    // Space is available when empty or when the held word leaves this
    // cycle. It is forced low while reset is asserted so nothing enters.
    assign can_load = rst_n && (!tvalid || tready);

    // Every byte of every word carries pixel data.
    assign tkeep = KEEP_ALL;

    // A load replaces the word, even in a handshake cycle, so tvalid stays
    // high. A handshake with nothing new to load empties the slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tuser  <= 1'b0;
            tlast  <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= load_data;
            tuser  <= load_user;
            tlast  <= load_last;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_word_packer.sv
// Transmit-side video framer. It accepts one 24-bit pixel per handshake and
// packs every four pixels into three 32-bit AXI4-Stream words. It marks
// start of frame on tuser and end of line on tlast.
// An in_sof that arrives away from the frame origin realigns the counters:
// partially packed bytes are dropped and that pixel starts a new frame.
module pixel_word_packer
    import video_stream_pkg::*;
#(
    parameter int X_PIX  = 640,
    parameter int Y_SIZE = 480
)
(
    input  logic              out_stream_aclk,
    input  logic              periph_resetn,
    input  logic [PIX_W-1:0]  in_pixel,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    output logic [WORD_W-1:0] out_stream_tdata,
    output logic [3:0]        out_stream_tkeep,
    output logic              out_stream_tvalid,
    input  logic              out_stream_tready,
    output logic              out_stream_tuser,
    output logic              out_stream_tlast,
    output logic              err_resync
);

    localparam int PX_W = $clog2(X_PIX);
    localparam int Y_W  = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

    localparam logic [PX_W-1:0] PX_LAST = PX_W'(X_PIX - 1);
    localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(Y_SIZE - 1);

    logic [PX_W-1:0]   px;
    logic [PX_W-1:0]   px_eff;
    logic [PX_W-1:0]   px_next;
    logic [Y_W-1:0]    y;
    logic [Y_W-1:0]    y_eff;
    logic [Y_W-1:0]    y_next;
    logic [PIX_W-1:0]  lo;
    logic [PIX_W-1:0]  lo_eff;
    logic              accept;
    logic              resync;
    phase_e            phase;
    logic [WORD_W-1:0] word;
    logic              word_load;
    logic              word_user;
    logic              word_last;

    assign accept = in_valid && in_ready;

    // Only an accepted in_sof counts. At the origin it is the normal case.
    assign resync = accept && in_sof && ((px != '0) || (y != '0));

    // Position and leftover bytes as seen by the current pixel. A resync
    // makes the pixel behave as the first pixel of a fresh frame.
    always_comb begin
        px_eff = px;
        y_eff  = y;
        lo_eff = lo;
        if (resync) begin
            px_eff = '0;
            y_eff  = '0;
            lo_eff = '0;
        end
        phase = phase_e'(px_eff[1:0]);
    end

    // Position after the current pixel. It wraps at end of line and at
    // end of frame.
    always_comb begin
        px_next = px_eff + PX_W'(1);
        y_next  = y_eff;
        if (px_eff == PX_LAST) begin
            px_next = '0;
            y_next  = (y_eff == Y_LAST) ? '0 : y_eff + Y_W'(1);
        end
    end

    // Word produced by this pixel and its framing flags.
    // The first word of a frame completes at x=1 of line 0.
    // The last word of a line completes on the last pixel of the line.
    always_comb begin
        word      = pack_word(phase, lo_eff, in_pixel);
        word_load = accept && (phase != PH_LOAD);
        word_user = (px_eff == PX_W'(1)) && (y_eff == '0);
        word_last = (px_eff == PX_LAST);
    end

    // Advance the counters and keep the bytes that did not fit in the
    // emitted word. They are kept right-aligned so pack_word can append
    // them as the low bytes of the next word.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            px <= '0;
            y  <= '0;
            lo <= '0;
        end else if (accept) begin
            px <= px_next;
            y  <= y_next;
            case (phase)
                PH_LOAD:   lo <= in_pixel;
                PH_FIRST:  lo <= {8'h00, in_pixel[23:8]};
                PH_SECOND: lo <= {16'h0000, in_pixel[23:16]};
                default:   lo <= lo;
            endcase
        end
    end

    // Flag a misplaced start of frame for exactly the cycle after it.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            err_resync <= 1'b0;
        end else begin
            err_resync <= resync;
        end
    end

    axis_out_slice u_out_slice (
        .clk       (out_stream_aclk),
        .rst_n     (periph_resetn),
        .load      (word_load),
        .load_data (word),
        .load_user (word_user),
        .load_last (word_last),
        .can_load  (in_ready),
        .tdata     (out_stream_tdata),
        .tkeep     (out_stream_tkeep),
        .tvalid    (out_stream_tvalid),
        .tready    (out_stream_tready),
        .tuser     (out_stream_tuser),
        .tlast     (out_stream_tlast)
    );

endmodule

// File: tb/tb_pixel_word_packer.sv
// Self-checking bench for pixel_word_packer using a small 8x2 frame.
// Expected words come from a byte-stream model. Each accepted pixel
// appends its three bytes, and every four bytes form a word LSB first.
// Framing flags come from the pixel's index in the frame.
module tb_pixel_word_packer;

    localparam int XP        = 8;
    localparam int YS        = 2;
    localparam int WPL       = XP * 3 / 4;
    localparam int FRAME_PIX = XP * YS;

    typedef struct packed {
        logic [31:0] d;
        logic        u;
        logic        l;
    } word_t;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [23:0] in_pixel = '0;
    logic        in_valid = 1'b0;
    logic        in_sof   = 1'b0;
    logic        in_ready;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tready   = 1'b1;
    logic        tuser;
    logic        tlast;
    logic        err_resync;

    word_t       act_q[$];
    word_t       exp_q[$];
    word_t       ready_words[$];
    logic [23:0] frame_pix[$];
    logic [7:0]  bq[$];
    int          pos           = 0;
    int          checks        = 0;
    int          failures      = 0;
    bit          bp_en         = 1'b0;
    bit          stalled       = 1'b0;
    word_t       stall_w;
    int          resync_pulses = 0;
    int          slow_accepts  = 0;

    pixel_word_packer #(.X_PIX(XP), .Y_SIZE(YS)) dut (
        .out_stream_aclk   (clk),
        .periph_resetn     (rst_n),
        .in_pixel          (in_pixel),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_sof            (in_sof),
        .out_stream_tdata  (tdata),
        .out_stream_tkeep  (tkeep),
        .out_stream_tvalid (tvalid),
        .out_stream_tready (tready),
        .out_stream_tuser  (tuser),
        .out_stream_tlast  (tlast),
        .err_resync        (err_resync)
    );

    // 10-time-unit clock.
    always #5 clk = ~clk;

    // Downstream ready: always high, or a coin toss every cycle when
    // backpressure is enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor on the falling edge. It records handshaken words,
    // checks that a stalled word holds, counts err_resync cycles,
    // and checks that no pixel is taken while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (tvalid !== 1'b1 || word_t'({tdata, tuser, tlast}) !== stall_w) begin
                    failures++;
                    $display("[TB] FAIL stall_hold: got v=%0b d=%h u=%0b l=%0b, required v=1 d=%h u=%0b l=%0b",
                             tvalid, tdata, tuser, tlast, stall_w.d, stall_w.u, stall_w.l);
                end
            end
            if (tvalid && !tready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stall_ready: in_ready=%0b while output stalled, required 0", in_ready);
                end
            end
            stalled = tvalid && !tready;
            stall_w = word_t'({tdata, tuser, tlast});
            if (tvalid && tready) act_q.push_back(word_t'({tdata, tuser, tlast}));
            if (err_resync === 1'b1) resync_pulses++;
        end
    end

    // Stop the run if it exceeds its time budget.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: a byte stream that starts a new frame on in_sof.
    task automatic model_accept(input logic [23:0] p, input logic sof);
        word_t w;
        if (sof && pos != 0) begin
            bq.delete();
            pos = 0;
        end
        for (int b = 0; b < 3; b++) bq.push_back(p[8*b +: 8]);
        if (bq.size() >= 4) begin
            w.d = {bq[3], bq[2], bq[1], bq[0]};
            w.u = (pos == 1);
            w.l = ((pos % XP) == XP - 1);
            exp_q.push_back(w);
            repeat (4) void'(bq.pop_front());
        end
        pos = (pos + 1) % FRAME_PIX;
    endtask

    // Offer one pixel until accepted (called and returning at posedge+1).
    task automatic send_pixel(input logic [23:0] p, input logic sof);
        bit done;
        done     = 1'b0;
        in_pixel = p;
        in_sof   = sof;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                model_accept(p, sof);
                if (i != 0) slow_accepts++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: pixel %h not accepted within 200 cycles", p);
        end
    endtask

    // Wait until every modelled word has been seen on the output.
    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (act_q.size() >= exp_q.size()) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_pixel = 24'h123456;
        in_sof   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (tvalid !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_hold: tvalid=%0b in_ready=%0b, required 0 0", tvalid, in_ready);
            end
            checks++;
            if (tdata !== 32'h0 || tuser !== 1'b0 || tlast !== 1'b0 || err_resync !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_outputs: d=%h u=%0b l=%0b err=%0b, required all zero",
                         tdata, tuser, tlast, err_resync);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ready_after_reset: in_ready=%0b, required 1", in_ready);
        end
        checks++;
        if (tkeep !== 4'hF || tvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL keep_valid_after_reset: tkeep=%h tvalid=%0b, required F 0", tkeep, tvalid);
        end
        @(posedge clk);
        #1;
        pos = 0;
        bq.delete();
        exp_q.delete();
        act_q.delete();
    endtask

    task automatic test_packing();
        logic [23:0] pix;
        logic [31:0] want;
        bit          ok;
        resync_pulses = 0;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin pix = 24'hA1A2A3; want = 32'h0;        end
                1: begin pix = 24'hB1B2B3; want = 32'hB3A1A2A3; end
                2: begin pix = 24'hC1C2C3; want = 32'hC2C3B1B2; end
                default: begin pix = 24'hD1D2D3; want = 32'hD1D2D3C1; end
            endcase
            send_pixel(pix, k == 0);
            @(negedge clk);
            checks++;
            if (k == 0) begin
                if (tvalid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL pack_first_pixel: tvalid=%0b, required 0", tvalid);
                end
            end else if (tvalid !== 1'b1 || tdata !== want || tuser !== (k == 1) || tlast !== 1'b0) begin
                failures++;
                $display("[TB] FAIL pack_word%0d: got v=%0b d=%h u=%0b l=%0b, required v=1 d=%h u=%0b l=0",
                         k, tvalid, tdata, tuser, tlast, want, (k == 1));
            end
            @(posedge clk);
            #1;
        end
        for (int n = 4; n < FRAME_PIX; n++) send_pixel(24'($urandom), 1'b0);
        wait_drain(ok);
        checks++;
        if (!ok || act_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL pack_count: got %0d words, required %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL pack_stream[%0d]: got d=%h u=%0b l=%0b, required d=%h u=%0b l=%0b",
                         i, act_q[i].d, act_q[i].u, act_q[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
            end
        end
        checks++;
        if (resync_pulses != 0) begin
            failures++;
            $display("[TB] FAIL pack_no_resync: err_resync cycles=%0d, required 0", resync_pulses);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic test_full_frame();
        logic [23:0] p;
        bit          ok;
        bp_en         = 1'b0;
        resync_pulses = 0;
        slow_accepts  = 0;
        frame_pix.delete();
        for (int n = 0; n < 3 * FRAME_PIX; n++) begin
            p = 24'($urandom);
            frame_pix.push_back(p);
            send_pixel(p, (n % FRAME_PIX) == 0);
        end
        wait_drain(ok);
        checks++;
        if (!ok || act_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL frame_count: got %0d words, required %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL frame_stream[%0d]: got d=%h u=%0b l=%0b, required d=%h u=%0b l=%0b",
                         i, act_q[i].d, act_q[i].u, act_q[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
            end
        end
        for (int i = 0; i < act_q.size(); i++) begin
            checks++;
            if (act_q[i].l !== ((i % WPL) == WPL - 1) || act_q[i].u !== ((i % (WPL * YS)) == 0)) begin
                failures++;
                $display("[TB] FAIL frame_flags[%0d]: got u=%0b l=%0b, required u=%0b l=%0b",
                         i, act_q[i].u, act_q[i].l, ((i % (WPL * YS)) == 0), ((i % WPL) == WPL - 1));
            end
        end
        checks++;
        if (slow_accepts != 0 || resync_pulses != 0) begin
            failures++;
            $display("[TB] FAIL frame_throughput: slow accepts=%0d err_resync cycles=%0d, required 0 0",
                     slow_accepts, resync_pulses);
        end
        ready_words = act_q;
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back_backpressure();
        bit ok;
        bp_en = 1'b1;
        for (int n = 0; n < frame_pix.size(); n++) send_pixel(frame_pix[n], (n % FRAME_PIX) == 0);
        wait_drain(ok);
        bp_en = 1'b0;
        checks++;
        if (!ok || act_q.size() != exp_q.size() || act_q.size() != ready_words.size()) begin
            failures++;
            $display("[TB] FAIL bp_count: got %0d words, required %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size() && i < ready_words.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i] || act_q[i] !== ready_words[i]) begin
                failures++;
                $display("[TB] FAIL bp_stream[%0d]: got d=%h u=%0b l=%0b, required d=%h u=%0b l=%0b",
                         i, act_q[i].d, act_q[i].u, act_q[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic test_resync();
        logic [23:0] p5;
        logic [23:0] p6;
        word_t       w;
        bit          ok;
        resync_pulses = 0;
        for (int n = 0; n < XP + 5; n++) send_pixel(24'($urandom), n == 0);
        p5 = 24'($urandom);
        p6 = 24'($urandom);
        send_pixel(p5, 1'b1);
        send_pixel(p6, 1'b0);
        for (int n = 2; n < FRAME_PIX; n++) send_pixel(24'($urandom), 1'b0);
        wait_drain(ok);
        checks++;
        if (!ok || act_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL resync_count: got %0d words, required %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL resync_stream[%0d]: got d=%h u=%0b l=%0b, required d=%h u=%0b l=%0b",
                         i, act_q[i].d, act_q[i].u, act_q[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
            end
        end
        w.d = {p6[7:0], p5};
        w.u = 1'b1;
        w.l = 1'b0;
        checks++;
        if (act_q.size() < 10 || act_q[9] !== w) begin
            failures++;
            $display("[TB] FAIL resync_first_word: got %0d words, word9=%h, required word9 d=%h u=1 l=0",
                     act_q.size(), (act_q.size() >= 10) ? act_q[9] : '0, w.d);
        end
        checks++;
        if (resync_pulses != 1) begin
            failures++;
            $display("[TB] FAIL resync_pulse: err_resync cycles=%0d, required 1", resync_pulses);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_line();
        bit ok;
        resync_pulses = 0;
        for (int n = 0; n < 5; n++) send_pixel(24'($urandom), n == 0);
        wait_drain(ok);
        checks++;
        if (!ok || act_q.size() != 3 || act_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL midline_pre_count: got %0d words, required 3", act_q.size());
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midline_reset: tvalid=%0b in_ready=%0b, required 0 0", tvalid, in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pos   = 0;
        bq.delete();
        act_q.delete();
        exp_q.delete();
        for (int n = 0; n < 2 * FRAME_PIX; n++) send_pixel(24'($urandom), 1'b0);
        wait_drain(ok);
        checks++;
        if (!ok || act_q.size() != exp_q.size()) begin
            failures++;
            $display("[TB] FAIL midline_count: got %0d words, required %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL midline_stream[%0d]: got d=%h u=%0b l=%0b, required d=%h u=%0b l=%0b",
                         i, act_q[i].d, act_q[i].u, act_q[i].l, exp_q[i].d, exp_q[i].u, exp_q[i].l);
            end
        end
        checks++;
        if (act_q.size() < 6 || act_q[0].u !== 1'b1 || act_q[5].l !== 1'b1 ||
            act_q[0].l !== 1'b0 || act_q[4].l !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midline_framing: words=%0d, required word0 u=1 and tlast first on word 5",
                     act_q.size());
        end
        checks++;
        if (resync_pulses != 0) begin
            failures++;
            $display("[TB] FAIL midline_no_resync: err_resync cycles=%0d, required 0", resync_pulses);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    // Run the scenarios in order, then report.
    initial begin
        test_reset();
        test_packing();
        test_full_frame();
        test_back_to_back_backpressure();
        test_resync();
        test_reset_mid_line();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_word_packer.md
# pixel_word_packer

Transmit-side AXI4-Stream video framer that sits between the fractal pixel datapath and the VDMA-facing output stream. It accepts one 24-bit RGB pixel per handshake, packs every 4 pixels into 3 32-bit words, and drives the output AXI-Stream with start-of-frame on `tuser` and end-of-line on `tlast`. Its output port is the side the stream-checking bench consumes, so every framing rule that bench checks is a requirement here.

## Interface
- `X_PIX`, 640: pixels per line; must be a multiple of 4. Words per line = `X_PIX*3/4`, 480 at the default.
- `Y_SIZE`, 480: lines per frame.
- `out_stream_aclk`  in  1  the single clock.
- `periph_resetn`  in  1  reset, asynchronous assert, active-low.
- `in_pixel`  in  24  RGB pixel, `{R,G,B}`.
- `in_valid`  in  1  pixel valid.
- `in_ready`  out  1  pixel accepted when `in_valid && in_ready`.
- `in_sof`  in  1  marks the first pixel of a frame; used for resynchronisation.
- `out_stream_tdata`  out  32  packed word.
- `out_stream_tkeep`  out  4  constant `4'hF`.
- `out_stream_tvalid`  out  1  word valid.
- `out_stream_tready`  in  1  downstream ready.
- `out_stream_tuser`  out  1  SOF: first word of a frame.
- `out_stream_tlast`  out  1  EOL: last word of each line.
- `err_resync`  out  1  one-cycle pulse when `in_sof` arrives off-position.

## Operation
- Counters: pixel x `px` runs 0..X_PIX-1, and line `y` runs 0..Y_SIZE-1. Both advance on each accepted pixel and wrap. `phase = px[1:0]`.
- Leftover register `lo` (24 b) holds the bytes not yet emitted.
- Action per accepted pixel `p`, by phase:
  - Phase 0: `lo <= p`; no word emitted.
  - Phase 1: emit `{p[7:0], lo[23:0]}`; `lo <= p[23:8]`.
  - Phase 2: emit `{p[15:0], lo[15:0]}`; `lo <= p[23:16]`.
  - Phase 3: emit `{p[23:0], lo[7:0]}`.
- `tuser` of an emitted word = 1 iff it is produced at `px==1 && y==0`.
- `tlast` of an emitted word = 1 iff it is produced at `px==X_PIX-1`.
- Output stage is a single register slice: `tdata`, `tuser`, `tlast` and `tvalid` are registered.
- `in_ready = periph_resetn && (!out_stream_tvalid || out_stream_tready)`, the same in all phases.
- Resync: an accepted pixel with `in_sof=1` while `(px,y)!=(0,0)` is handled as follows.
  - Pulse `err_resync` for one cycle.
  - Discard `lo`.
  - Treat that pixel as `px=0, y=0` (phase 0).
  - An `in_sof` at `(0,0)` is normal and produces no pulse.
  - `in_sof` on a non-accepted cycle is ignored.

## Timing
- Reset values: `tvalid` 0, `tdata` 0, `tuser` 0, `tlast` 0, `err_resync` 0, `in_ready` 0, `px=y=0`, `lo=0`. Reset clears all state immediately.
- After reset is released, `in_ready` is 1 in the first cycle.
- Latency: a word is valid on the clock edge after the pixel that completes it is accepted.
- Throughput: with `tready` held at 1, one pixel is accepted every cycle and the output shows 3 valid words per 4 cycles. The only `tvalid` gaps are at phase-0 pixels.
- AXI rule: while `tvalid && !tready`, `tdata`, `tuser` and `tlast` hold stable and no pixel is accepted.
- `tvalid` deasserts only after a handshake with no new word loaded in the same cycle.
- When a handshake and the load of a new word happen in the same cycle, the new word replaces the old one and `tvalid` stays 1.
- A phase-0 acceptance coinciding with a handshake clears `tvalid`.
- Frame wrap: at `px==X_PIX-1 && y==Y_SIZE-1` both counters go to 0. The next frame's first word carries `tuser=1`.
- Reset mid-line: the partial line is dropped. The first word after reset carries `tuser=1`.

## Structure
- Package `video_stream_pkg`:
  - widths `PIX_W=24` and `WORD_W=32`;
  - `KEEP_ALL=4'hF`;
  - function `pack_word(phase, lo, p)` returning the 32-bit word.
- Sub-module `axis_out_slice`: the registered output stage with its ready/valid logic.
- Counters, phase handling and resync logic stay in the top module.

## Test plan
- Reset: hold `periph_resetn` low for 3 cycles with `in_valid=1`.
  - During reset: `tvalid=0`, `in_ready=0`, and no pixel is taken.
  - After release: `in_ready=1` in the first cycle.
- Packing (`X_PIX=8`, `Y_SIZE=2`): send pixels `A1A2A3`, `B1B2B3`, `C1C2C3`, `D1D2D3`.
  - Required words: `B3A1A2A3`, `C2C3B1B2`, `D1D2D3C1`.
  - First word has `tuser=1`; `tlast=0` on all three.
- Full frame at defaults with `tready=1` and `in_sof` on pixel 0.
  - Each line: 480 words, `tlast` on word 479 only.
  - Each frame: 230400 words, `tuser` only on word 0.
  - Second frame: `tuser` again on its word 0.
- Random backpressure (50% PRBS on `tready`) on the same frame stream.
  - Word sequence is identical to the always-ready case.
  - `tdata`/`tuser`/`tlast` never change while stalled.
- Resync (`X_PIX=8`): assert `in_sof` on pixel 5 of line 1.
  - `err_resync` pulses for exactly 1 cycle.
  - Words 2 and 3 of that pixel group come from the new alignment; the first of them carries `tuser=1`.
- Reset mid-line: assert reset after 3 words of line 0, then restart the pixel stream.
  - First output word after reset has `tuser=1`.
  - `tlast` appears on word 5 (`X_PIX=8`).
